sct_cascade_counter: RTL and testbench
======================================

SCT_CASCADE_COUNTER -- requirements
Module: sct_cascade_counter

Interface
REQ-001 Parameter: WIDTH, default 8, counter width in bits (legal range 2..32).
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: en  input  1  count enable.
REQ-005 Port: ci  input  1  cascade carry-in; a count step requires en=1 and ci=1.
REQ-006 Port: dir  input  1  0 = count up, 1 = count down.
REQ-007 Port: mode  input  1  0 = free-run, 1 = one-shot.
REQ-008 Port: start  input  1  begin counting.
REQ-009 Port: stop  input  1  halt counting.
REQ-010 Port: clr  input  1  synchronous clear.
REQ-011 Port: load  input  1  synchronous parallel load.
REQ-012 Port: din  input  WIDTH  load value.
REQ-013 Port: q  output  WIDTH  registered count.
REQ-014 Port: tc  output  1  terminal count: q equals all-ones when dir=0, or zero when dir=1; combinational.
REQ-015 Port: co  output  1  cascade carry-out = step & tc; combinational.
REQ-016 Port: busy  output  1  state is RUN.
REQ-017 Port: done  output  1  state is DONE.

Function
REQ-018 States: IDLE, RUN, DONE; busy and done are decoded directly from the state register.
REQ-019 step = (state==RUN) & en & ci.
REQ-020 State transitions: IDLE->RUN on start; DONE->RUN on start; RUN->IDLE on stop; start & stop together in RUN -> IDLE; start is ignored in RUN; stop is ignored outside RUN.
REQ-021 q priority per cycle: clr (q=0) > load (q=din) > step > hold.
REQ-022 clr forces state to IDLE; load does not change state.
REQ-023 Non-terminal step: q increments by 1 (dir=0) or decrements by 1 (dir=1), modulo 2^WIDTH.
REQ-024 Terminal step in free-run mode (mode=0): q wraps to 0 (up) or to all-ones (down); state stays RUN.
REQ-025 Terminal step in one-shot mode (mode=1): q holds; state goes to DONE.
REQ-026 co is asserted in the same cycle as a terminal step, in either mode, so that cascaded instances (co->ci) advance on the same clock edge.
REQ-027 A change of dir or mode takes effect on the next step; tc re-evaluates immediately.
REQ-028 A load or clr coinciding with a terminal step suppresses the wrap and the DONE transition; co still reflects step & tc for that cycle.

Reset
REQ-029 While rst=1: q=0, state=IDLE, busy=0, done=0, independent of clk.
REQ-030 co and tc follow their combinational equations from the reset values; co=0 during reset.
REQ-031 Reset asserted mid-count aborts the count with no residual state.

Configuration
REQ-032 Macro SCT_SAT_EN defined: free-run terminal steps saturate, i.e. q holds at the terminal value, co asserts on each such step, and state stays RUN.
REQ-033 Macro SCT_SAT_EN undefined: free-run terminal steps wrap as in REQ-024; one-shot behaviour is identical in both builds.

Verification (WIDTH=4 unless stated)
REQ-034 Up wrap: mode=0, dir=0, en=ci=1, start -> q steps 0..15; co=1 only while q=15; next q=0. With SCT_SAT_EN, q stays 15 and co=1 every cycle.
REQ-035 One-shot down: load din=3, dir=1, mode=1, start -> q 3,2,1,0; then done=1, busy=0, q held at 0; a further start -> RUN, and q remains 0 while done clears.
REQ-036 Priority: in RUN at q=7, clr=load=1 with din=9 and step active -> q=0, state IDLE, co=0.
REQ-037 Cascade: two instances, low.co -> high.ci, both RUN, en=1; combined count 0x0F -> 0x10 in one edge; with low ci=0 both hold.
REQ-038 Reset mid-operation: q=5 in RUN, rst pulsed between edges -> q=0 and IDLE immediately; start & stop together in RUN -> IDLE next cycle.

Source files
------------

// File: rtl/sct_cascade_counter.sv
// Cascadable up/down counter with IDLE/RUN/DONE control, one-shot and free-run modes.
// Build option: define SCT_SAT_EN to make free-run terminal steps saturate instead of wrapping.
module sct_cascade_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ci,
  input  logic             dir,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             co,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t state;
  logic   step;

  // tc looks at the current dir so a direction change is seen before the next step
  assign tc   = dir ? (q == '0) : (q == ALL_ONES);
  assign step = (state == RUN) & en & ci;
  assign co   = step & tc;
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // NOTE: state and count use non-blocking assignments so every branch reads pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      state <= IDLE;
    end else if (clr) begin
      q     <= '0;
      state <= IDLE;
    end else begin
      if (load) begin
        q <= din;
      end else if (step) begin
        if (!tc) begin
          q <= dir ? q - WIDTH'(1) : q + WIDTH'(1);
        end else if (!mode) begin
`ifdef SCT_SAT_EN
          q <= q;
`else
          q <= dir ? ALL_ONES : '0;
`endif
        end
      end

      // A load on the terminal step keeps the count alive instead of finishing it
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (stop)                              state <= IDLE;
          else if (step && tc && mode && !load)  state <= DONE;
        end
        DONE: if (start) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sct_cascade_counter.sv
// Self-checking bench for sct_cascade_counter (WIDTH=4): directed scenarios, a two-stage
// cascade, and a randomized run compared against an arithmetic reference model.
module tb_sct_cascade_counter;

  localparam int W    = 4;
  localparam int MAXV = 15;
`ifdef SCT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, ci = 1'b0, dir = 1'b0, mode = 1'b0;
  logic         start = 1'b0, stop = 1'b0, clr = 1'b0, load = 1'b0;
  logic [W-1:0] din = '0;
  logic [W-1:0] q;
  logic         tc, co, busy, done;

  logic         c_start = 1'b0, c_ci = 1'b0, c_load = 1'b0;
  logic [W-1:0] lo_din = '0, hi_din = '0;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_tc, hi_tc, lo_co, hi_co, lo_busy, hi_busy, lo_done, hi_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sct_cascade_counter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .ci(ci), .dir(dir), .mode(mode),
    .start(start), .stop(stop), .clr(clr), .load(load), .din(din),
    .q(q), .tc(tc), .co(co), .busy(busy), .done(done)
  );

  sct_cascade_counter #(.WIDTH(W)) u_lo (
    .clk(clk), .rst(rst), .en(1'b1), .ci(c_ci), .dir(1'b0), .mode(1'b0),
    .start(c_start), .stop(1'b0), .clr(1'b0), .load(c_load), .din(lo_din),
    .q(lo_q), .tc(lo_tc), .co(lo_co), .busy(lo_busy), .done(lo_done)
  );

  sct_cascade_counter #(.WIDTH(W)) u_hi (
    .clk(clk), .rst(rst), .en(1'b1), .ci(lo_co), .dir(1'b0), .mode(1'b0),
    .start(c_start), .stop(1'b0), .clr(1'b0), .load(c_load), .din(hi_din),
    .q(hi_q), .tc(hi_tc), .co(hi_co), .busy(hi_busy), .done(hi_done)
  );

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic clear_inputs();
    en = 0; ci = 0; dir = 0; mode = 0; start = 0; stop = 0; clr = 0; load = 0; din = '0;
    c_start = 0; c_ci = 0; c_load = 0; lo_din = '0; hi_din = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    checks++; if (q !== 4'd0)   begin errors++; $display("FAIL reset_q: got %0d expected 0", q); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (co !== 1'b0)   begin errors++; $display("FAIL reset_co: got %b expected 0", co); end
    checks++; if (tc !== 1'b0)   begin errors++; $display("FAIL reset_tc_up: got %b expected 0", tc); end
    dir = 1'b1; en = 1'b1; ci = 1'b1; start = 1'b1;
    #1;
    checks++; if (tc !== 1'b1)   begin errors++; $display("FAIL reset_tc_down: got %b expected 1", tc); end
    @(negedge clk); #1;
    checks++; if (q !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_held: got q=%0d busy=%b expected q=0 busy=0", q, busy);
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  task automatic test_up_wrap();
    int exp_q;
    do_reset();
    en = 1; ci = 1;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 19; i++) begin
      #1;
      exp_q = SAT ? ((i > MAXV) ? MAXV : i) : (i % (MAXV + 1));
      checks++; if (q !== W'(exp_q)) begin
        errors++; $display("FAIL up_wrap_q[%0d]: got %0d expected %0d", i, q, exp_q);
      end
      checks++; if (co !== (exp_q == MAXV)) begin
        errors++; $display("FAIL up_wrap_co[%0d]: got %b expected %b", i, co, exp_q == MAXV);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_oneshot_down();
    int seq [4] = '{3, 2, 1, 0};
    do_reset();
    dir = 1; mode = 1; en = 1; ci = 1;
    din = 4'd3; load = 1;
    @(negedge clk); load = 0; start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (q !== W'(seq[i]) || busy !== 1'b1 || done !== 1'b0) begin
        errors++; $display("FAIL oneshot_run[%0d]: got q=%0d busy=%b done=%b expected q=%0d busy=1 done=0",
                           i, q, busy, done, seq[i]);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b1 || co !== 1'b0) begin
        errors++; $display("FAIL oneshot_done[%0d]: got q=%0d busy=%b done=%b co=%b expected 0 0 1 0",
                           i, q, busy, done, co);
      end
      @(negedge clk);
    end
    start = 1;
    @(negedge clk); start = 0; #1;
    checks++; if (q !== 4'd0 || busy !== 1'b1 || done !== 1'b0 || co !== 1'b1) begin
      errors++; $display("FAIL oneshot_restart: got q=%0d busy=%b done=%b co=%b expected 0 1 0 1",
                         q, busy, done, co);
    end
    @(negedge clk); #1;
    checks++; if (done !== 1'b1 || q !== 4'd0) begin
      errors++; $display("FAIL oneshot_redone: got q=%0d done=%b expected q=0 done=1", q, done);
    end
  endtask

  task automatic test_priority();
    do_reset();
    ci = 1; din = 4'd7; load = 1;
    @(negedge clk); load = 0; start = 1;
    @(negedge clk); start = 0; en = 1; clr = 1; load = 1; din = 4'd9; #1;
    checks++; if (q !== 4'd7 || busy !== 1'b1) begin
      errors++; $display("FAIL prio_setup: got q=%0d busy=%b expected q=7 busy=1", q, busy);
    end
    @(negedge clk); clr = 0; load = 0; #1;
    checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || co !== 1'b0) begin
      errors++; $display("FAIL prio_clr: got q=%0d busy=%b done=%b co=%b expected 0 0 0 0", q, busy, done, co);
    end
    // load landing on a one-shot terminal step: co fires, no DONE, new value taken
    mode = 1; en = 0; din = 4'd15; load = 1; start = 1;
    @(negedge clk); start = 0; en = 1; din = 4'd5; #1;
    checks++; if (co !== 1'b1) begin
      errors++; $display("FAIL load_term_co: got %b expected 1", co);
    end
    @(negedge clk); load = 0; en = 0; #1;
    checks++; if (q !== 4'd5 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL load_term_state: got q=%0d busy=%b done=%b expected 5 1 0", q, busy, done);
    end
  endtask

  task automatic test_cascade();
    do_reset();
    lo_din = 4'hF; hi_din = 4'h0; c_load = 1;
    @(negedge clk); c_load = 0; c_start = 1; c_ci = 0;
    @(negedge clk); c_start = 0; #1;
    checks++; if ({hi_q, lo_q} !== 8'h0F || lo_co !== 1'b0) begin
      errors++; $display("FAIL cascade_hold_a: got %h co=%b expected 0f co=0", {hi_q, lo_q}, lo_co);
    end
    @(negedge clk); #1;
    checks++; if ({hi_q, lo_q} !== 8'h0F) begin
      errors++; $display("FAIL cascade_hold_b: got %h expected 0f", {hi_q, lo_q});
    end
    c_ci = 1; #1;
    checks++; if (lo_co !== 1'b1 || hi_co !== 1'b0) begin
      errors++; $display("FAIL cascade_co: got lo=%b hi=%b expected lo=1 hi=0", lo_co, hi_co);
    end
    @(negedge clk); c_ci = 0; #1;
    checks++; if ({hi_q, lo_q} !== 8'h10 || lo_busy !== 1'b1 || hi_busy !== 1'b1) begin
      errors++; $display("FAIL cascade_step: got %h busy=%b%b expected 10 busy=11",
                         {hi_q, lo_q}, hi_busy, lo_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    din = 4'd5; load = 1; start = 1;
    @(negedge clk); load = 0; start = 0; #1;
    checks++; if (q !== 4'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got q=%0d busy=%b expected 5 1", q, busy);
    end
    #1 rst = 1; #1;
    checks++; if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || co !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got q=%0d busy=%b done=%b co=%b expected 0 0 0 0", q, busy, done, co);
    end
    rst = 0;
    @(negedge clk); start = 1;
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL startstop_setup: got busy=%b expected 1", busy);
    end
    stop = 1;
    @(negedge clk); start = 0; stop = 0; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL startstop_idle: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    int m_q, m_st, n_q, n_st;
    bit m_tc, m_step, m_co;
    do_reset();
    m_q = 0; m_st = M_IDLE;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      en    = ($urandom_range(3) != 0);
      ci    = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) dir = ~dir;
      if ($urandom_range(31) == 0) mode = ~mode;
      start = ($urandom_range(5) == 0);
      stop  = ($urandom_range(19) == 0);
      clr   = ($urandom_range(39) == 0);
      load  = ($urandom_range(11) == 0);
      din   = W'($urandom_range(MAXV));
      #1;
      m_tc   = dir ? (m_q == 0) : (m_q == MAXV);
      m_step = (m_st == M_RUN) && en && ci;
      m_co   = m_step && m_tc;
      checks++; if (q !== W'(m_q) || tc !== m_tc || co !== m_co ||
                    busy !== (m_st == M_RUN) || done !== (m_st == M_DONE)) begin
        errors++;
        $display("FAIL random[%0d]: got q=%0d tc=%b co=%b busy=%b done=%b expected q=%0d tc=%b co=%b busy=%b done=%b",
                 i, q, tc, co, busy, done, m_q, m_tc, m_co, m_st == M_RUN, m_st == M_DONE);
      end
      n_q = m_q; n_st = m_st;
      if (clr) begin
        n_q = 0; n_st = M_IDLE;
      end else begin
        if (load) n_q = din;
        else if (m_step) begin
          if (!m_tc)              n_q = dir ? (m_q + MAXV) % (MAXV + 1) : (m_q + 1) % (MAXV + 1);
          else if (mode || SAT)   n_q = m_q;
          else                    n_q = dir ? MAXV : 0;
        end
        if (m_st == M_RUN) begin
          if (stop) n_st = M_IDLE;
          else if (m_step && m_tc && mode && !load) n_st = M_DONE;
        end else if (start) begin
          n_st = M_RUN;
        end
      end
      m_q = n_q; m_st = n_st;
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_oneshot_down();
    test_priority();
    test_cascade();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
